// File: rtl/seq_mult_acc.sv
// Sequential shift-add multiplier with optional signed mode and an accumulate stage
// carrying a sticky signed-overflow flag. One multiply takes WIDTH+1 cycles.
module seq_mult_acc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  input  logic                   signed_mode,
  input  logic                   accumulate,
  input  logic                   clear_acc,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   overflow
);

  localparam int unsigned CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH:0]       work_q, work_d;
  logic [WIDTH-1:0]       mag_a_q, mag_a_d;
  logic                   neg_q, neg_d;
  logic                   sm_q, sm_d;
  logic                   accum_q, accum_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         add_sum;
  logic [2*WIDTH:0]       step, work_step;
  logic [2*WIDTH-1:0]     p_raw, prod_new;
  logic [ACC_WIDTH:0]     prod_ext, acc_sum;
  logic                   finish;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mag_a_d   = mag_a_q;
    neg_d     = neg_q;
    sm_d      = sm_q;
    accum_d   = accum_q;
    product_d = product_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    finish    = 1'b0;

    a_mag     = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
    b_mag     = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
    add_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    step      = work_q[0] ? {add_sum, work_q[WIDTH-1:0]} : work_q;
    work_step = step >> 1;
    p_raw     = work_step[2*WIDTH-1:0];
    prod_new  = neg_q ? -p_raw : p_raw;
    // One guard bit above ACC_WIDTH so an unsigned product that lands on the
    // accumulator sign bit still reports overflow.
    prod_ext  = {{(ACC_WIDTH+1-2*WIDTH){sm_q & prod_new[2*WIDTH-1]}}, prod_new};
    acc_sum   = {acc_q[ACC_WIDTH-1], acc_q} + prod_ext;

    case (state_q)
      // DONE also accepts start so back-to-back operations issue every WIDTH+1 cycles.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          mag_a_d = a_mag;
          work_d  = {{(WIDTH+1){1'b0}}, b_mag};
          neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          sm_d    = signed_mode;
          accum_d = accumulate;
          cnt_d   = CW'(WIDTH);
        end
      end
      RUN: begin
        work_d = work_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          finish    = 1'b1;
          product_d = prod_new;
          if (accum_q) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | (acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1]);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_acc) begin
      acc_d = (finish && accum_q) ? prod_ext[ACC_WIDTH-1:0] : '0;
      ovf_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = finish;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      mag_a_q   <= '0;
      neg_q     <= 1'b0;
      sm_q      <= 1'b0;
      accum_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      mag_a_q   <= mag_a_d;
      neg_q     <= neg_d;
      sm_q      <= sm_d;
      accum_q   <= accum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule
